// File: rtl/fx3_socket_scheduler.sv
// fx3_socket_scheduler
//   Arbitrates the FX3 host interface between the ingress path (host -> FPGA) and
//   the egress path (FPGA -> host). DMA sockets are picked round-robin within each
//   direction. Ingress bursts are capped while egress waits, and an optional
//   watchdog aborts a transaction that stops making progress.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   i_master_rdy             master can accept commands/data
//   o_host_interface_rdy     high unless an egress transaction is active
//   o_in_path_enable         ingress engine enable
//   i_in_path_finished       ingress transaction done
//   o_in_path_cmd_enable     command path enable
//   i_out_path_ready         egress data pending
//   o_out_path_enable        egress engine enable
//   i_out_path_finished      egress transaction done
//   o_out_dma_buf_ready      an egress socket is selected and ready
//   i_out_dma_buf_finished   current egress socket buffer consumed
//   i_in_ch_rdy              per-socket ingress data-available flags
//   i_out_ch_rdy             per-socket egress buffer-free flags
//   o_socket_addr            selected FX3 socket
//   o_timeout                one-cycle pulse on watchdog abort
module fx3_socket_scheduler #(
  parameter int unsigned IN_CHANNELS    = 2,
  parameter int unsigned OUT_CHANNELS   = 2,
  parameter int unsigned OUT_BASE       = 2,
  parameter int unsigned ADDR_WIDTH     = 2,
  parameter int unsigned MAX_IN_BURST   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_master_rdy,
  output logic                    o_host_interface_rdy,
  output logic                    o_in_path_enable,
  input  logic                    i_in_path_finished,
  output logic                    o_in_path_cmd_enable,
  input  logic                    i_out_path_ready,
  output logic                    o_out_path_enable,
  input  logic                    i_out_path_finished,
  output logic                    o_out_dma_buf_ready,
  input  logic                    i_out_dma_buf_finished,
  input  logic [IN_CHANNELS-1:0]  i_in_ch_rdy,
  input  logic [OUT_CHANNELS-1:0] i_out_ch_rdy,
  output logic [ADDR_WIDTH-1:0]   o_socket_addr,
  output logic                    o_timeout
);

  localparam int unsigned InPw   = (IN_CHANNELS > 1) ? $clog2(IN_CHANNELS) : 1;
  localparam int unsigned OutPw  = (OUT_CHANNELS > 1) ? $clog2(OUT_CHANNELS) : 1;
  localparam int unsigned BurstW = $clog2(MAX_IN_BURST + 1);
  localparam int unsigned WdW    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [InPw-1:0]   InLast   = InPw'(IN_CHANNELS - 1);
  localparam logic [OutPw-1:0]  OutLast  = OutPw'(OUT_CHANNELS - 1);
  localparam logic [BurstW-1:0] BurstMax = BurstW'(MAX_IN_BURST);
  localparam logic [WdW-1:0]    WdLast   = WdW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {StIdle, StInXfer, StOutActive} state_e;

  state_e                  state_q, state_d;
  logic [InPw-1:0]         in_ptr_q, in_ptr_d;
  logic [OutPw-1:0]        out_ptr_q, out_ptr_d;
  logic [BurstW-1:0]       burst_q, burst_d;
  logic [WdW-1:0]          wd_q, wd_d;
  logic                    in_en_q, in_en_d;
  logic                    out_en_q, out_en_d;
  logic                    cmd_en_q, cmd_en_d;
  logic                    dma_rdy_q, dma_rdy_d;
  logic                    timeout_q, timeout_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;

  logic                    in_any, out_any, starve;
  logic [InPw-1:0]         in_pick, in_pick_hi, in_pick_lo;
  logic                    in_hi_found;
  logic [OutPw-1:0]        out_pick, out_pick_hi, out_pick_lo;
  logic                    out_hi_found;

  assign in_any  = |i_in_ch_rdy;
  assign out_any = |i_out_ch_rdy;
  assign starve  = i_out_path_ready && (burst_q == BurstMax);

  // Round-robin pick: scanning downwards leaves the lowest ready index at or above
  // the pointer in *_hi and the lowest ready index overall (the wrap case) in *_lo.
  always_comb begin
    in_pick_hi  = '0;
    in_pick_lo  = '0;
    in_hi_found = 1'b0;
    for (int i = IN_CHANNELS - 1; i >= 0; i--) begin
      if (i_in_ch_rdy[i]) begin
        in_pick_lo = InPw'(i);
        if (InPw'(i) >= in_ptr_q) begin
          in_pick_hi  = InPw'(i);
          in_hi_found = 1'b1;
        end
      end
    end
    in_pick = in_hi_found ? in_pick_hi : in_pick_lo;
  end

  always_comb begin
    out_pick_hi  = '0;
    out_pick_lo  = '0;
    out_hi_found = 1'b0;
    for (int j = OUT_CHANNELS - 1; j >= 0; j--) begin
      if (i_out_ch_rdy[j]) begin
        out_pick_lo = OutPw'(j);
        if (OutPw'(j) >= out_ptr_q) begin
          out_pick_hi  = OutPw'(j);
          out_hi_found = 1'b1;
        end
      end
    end
    out_pick = out_hi_found ? out_pick_hi : out_pick_lo;
  end

  always_comb begin
    state_d   = state_q;
    in_ptr_d  = in_ptr_q;
    out_ptr_d = out_ptr_q;
    burst_d   = burst_q;
    wd_d      = '0;
    in_en_d   = in_en_q;
    out_en_d  = out_en_q;
    dma_rdy_d = dma_rdy_q;
    addr_d    = addr_q;
    timeout_d = 1'b0;

    // Command path stays enabled through transactions once the master is ready.
    cmd_en_d = cmd_en_q;
    if (i_master_rdy) begin
      cmd_en_d = 1'b1;
    end else if (state_q == StIdle) begin
      cmd_en_d = 1'b0;
    end

    case (state_q)
      StIdle: begin
        if (starve || (i_out_path_ready && !in_any)) begin
          state_d  = StOutActive;
          out_en_d = 1'b1;
          burst_d  = '0;
        end else if (i_master_rdy && in_any) begin
          state_d  = StInXfer;
          in_en_d  = 1'b1;
          addr_d   = ADDR_WIDTH'(in_pick);
          in_ptr_d = (in_pick == InLast) ? '0 : in_pick + InPw'(1);
          if (i_out_path_ready) begin
            burst_d = (burst_q == BurstMax) ? burst_q : burst_q + BurstW'(1);
          end else begin
            burst_d = '0;
          end
        end
      end
      StInXfer: begin
        if (i_in_path_finished) begin
          in_en_d = 1'b0;
          state_d = StIdle;
        end
      end
      StOutActive: begin
        // Exit beats buffer-finished, which beats reselection.
        if (i_out_path_finished) begin
          out_en_d  = 1'b0;
          dma_rdy_d = 1'b0;
          state_d   = StIdle;
        end else if (i_out_dma_buf_finished) begin
          dma_rdy_d = 1'b0;
        end else if (!dma_rdy_q && out_any) begin
          addr_d    = ADDR_WIDTH'(OUT_BASE) + ADDR_WIDTH'(out_pick);
          dma_rdy_d = 1'b1;
          out_ptr_d = (out_pick == OutLast) ? '0 : out_pick + OutPw'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    // Busy states leave only via a finished signal, so any finished strobe covers
    // both "progress" and "state change"; finished also wins over expiry.
    if ((TIMEOUT_CYCLES != 0) && (state_q != StIdle)) begin
      if (i_in_path_finished || i_out_dma_buf_finished || i_out_path_finished) begin
        wd_d = '0;
      end else if (wd_q == WdLast) begin
        timeout_d = 1'b1;
        in_en_d   = 1'b0;
        out_en_d  = 1'b0;
        dma_rdy_d = 1'b0;
        state_d   = StIdle;
      end else begin
        wd_d = wd_q + WdW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      in_ptr_q  <= '0;
      out_ptr_q <= '0;
      burst_q   <= '0;
      wd_q      <= '0;
      in_en_q   <= 1'b0;
      out_en_q  <= 1'b0;
      cmd_en_q  <= 1'b0;
      dma_rdy_q <= 1'b0;
      timeout_q <= 1'b0;
      addr_q    <= '0;
    end else begin
      state_q   <= state_d;
      in_ptr_q  <= in_ptr_d;
      out_ptr_q <= out_ptr_d;
      burst_q   <= burst_d;
      wd_q      <= wd_d;
      in_en_q   <= in_en_d;
      out_en_q  <= out_en_d;
      cmd_en_q  <= cmd_en_d;
      dma_rdy_q <= dma_rdy_d;
      timeout_q <= timeout_d;
      addr_q    <= addr_d;
    end
  end

  // Gated by rst so this unregistered output also reads 0 while reset is held.
  assign o_host_interface_rdy = ~rst & (state_q != StOutActive);
  assign o_in_path_enable     = in_en_q;
  assign o_in_path_cmd_enable = cmd_en_q;
  assign o_out_path_enable    = out_en_q;
  assign o_out_dma_buf_ready  = dma_rdy_q;
  assign o_socket_addr        = addr_q;
  assign o_timeout            = timeout_q;

endmodule

// File: tb/tb_fx3_socket_scheduler.sv
module tb_fx3_socket_scheduler;

  localparam int MIdle = 0;
  localparam int MIn   = 1;
  localparam int MOut  = 2;

  typedef struct packed {
    logic       master;
    logic       in_fin;
    logic       out_rdy;
    logic       out_fin;
    logic       dma_fin;
    logic [7:0] in_ch;
    logic [7:0] out_ch;
  } stim_t;

  typedef struct {
    int nin;
    int nout;
    int base;
    int aw;
    int maxb;
    int tmo;
  } cfg_t;

  typedef struct {
    int st;
    int in_ptr;
    int out_ptr;
    int burst;
    int wd;
    int addr;
    bit in_en;
    bit out_en;
    bit cmd_en;
    bit dma;
    bit tmo;
  } mdl_t;

  logic clk;
  logic rst;
  stim_t sa, sb;
  cfg_t cfg_a = '{2, 2, 2, 2, 4, 0};
  cfg_t cfg_b = '{5, 2, 8, 4, 4, 16};
  mdl_t ma, mb;
  int tests = 0;
  int fails = 0;

  logic a_host, a_in_en, a_cmd, a_out_en, a_dma, a_tmo;
  logic [1:0] a_addr;
  logic b_host, b_in_en, b_cmd, b_out_en, b_dma, b_tmo;
  logic [3:0] b_addr;

  fx3_socket_scheduler u_dut_a (
    .clk                    (clk),
    .rst                    (rst),
    .i_master_rdy           (sa.master),
    .o_host_interface_rdy   (a_host),
    .o_in_path_enable       (a_in_en),
    .i_in_path_finished     (sa.in_fin),
    .o_in_path_cmd_enable   (a_cmd),
    .i_out_path_ready       (sa.out_rdy),
    .o_out_path_enable      (a_out_en),
    .i_out_path_finished    (sa.out_fin),
    .o_out_dma_buf_ready    (a_dma),
    .i_out_dma_buf_finished (sa.dma_fin),
    .i_in_ch_rdy            (sa.in_ch[1:0]),
    .i_out_ch_rdy           (sa.out_ch[1:0]),
    .o_socket_addr          (a_addr),
    .o_timeout              (a_tmo)
  );

  fx3_socket_scheduler #(
    .IN_CHANNELS    (5),
    .OUT_CHANNELS   (2),
    .OUT_BASE       (8),
    .ADDR_WIDTH     (4),
    .MAX_IN_BURST   (4),
    .TIMEOUT_CYCLES (16)
  ) u_dut_b (
    .clk                    (clk),
    .rst                    (rst),
    .i_master_rdy           (sb.master),
    .o_host_interface_rdy   (b_host),
    .o_in_path_enable       (b_in_en),
    .i_in_path_finished     (sb.in_fin),
    .o_in_path_cmd_enable   (b_cmd),
    .i_out_path_ready       (sb.out_rdy),
    .o_out_path_enable      (b_out_en),
    .i_out_path_finished    (sb.out_fin),
    .o_out_dma_buf_ready    (b_dma),
    .i_out_dma_buf_finished (sb.dma_fin),
    .i_in_ch_rdy            (sb.in_ch[4:0]),
    .i_out_ch_rdy           (sb.out_ch[1:0]),
    .o_socket_addr          (b_addr),
    .o_timeout              (b_tmo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Lowest ready channel at or after ptr, wrapping round to channel 0.
  function automatic int rr_pick(int rdy, int ptr, int n);
    for (int k = ptr; k < n; k++) if (rdy[k]) return k;
    for (int k = 0; k < ptr; k++) if (rdy[k]) return k;
    return -1;
  endfunction

  // One clock of the scheduler as described by its rules.
  function automatic mdl_t step(mdl_t m, cfg_t c, stim_t s);
    mdl_t n;
    int in_bits, out_bits, pick;
    bit starve;
    n = m;
    n.tmo = 0;
    in_bits  = int'(s.in_ch) & ((1 << c.nin) - 1);
    out_bits = int'(s.out_ch) & ((1 << c.nout) - 1);
    if (s.master) n.cmd_en = 1;
    else if (m.st == MIdle) n.cmd_en = 0;
    if (m.st == MIdle) begin
      starve = s.out_rdy && (m.burst == c.maxb);
      if (starve || (s.out_rdy && in_bits == 0)) begin
        n.st = MOut; n.out_en = 1; n.burst = 0;
      end else if (s.master && in_bits != 0) begin
        pick = rr_pick(in_bits, m.in_ptr, c.nin);
        n.st = MIn; n.in_en = 1; n.addr = pick; n.in_ptr = (pick + 1) % c.nin;
        n.burst = s.out_rdy ? ((m.burst < c.maxb) ? m.burst + 1 : c.maxb) : 0;
      end
    end else if (m.st == MIn) begin
      if (s.in_fin) begin n.in_en = 0; n.st = MIdle; end
    end else begin
      if (s.out_fin) begin
        n.out_en = 0; n.dma = 0; n.st = MIdle;
      end else if (s.dma_fin) begin
        n.dma = 0;
      end else if (!m.dma && out_bits != 0) begin
        pick = rr_pick(out_bits, m.out_ptr, c.nout);
        n.addr = (c.base + pick) % (1 << c.aw);
        n.dma = 1; n.out_ptr = (pick + 1) % c.nout;
      end
    end
    if (c.tmo > 0 && m.st != MIdle) begin
      if (s.in_fin || s.out_fin || s.dma_fin || n.st != m.st) begin
        n.wd = 0;
      end else if (m.wd + 1 == c.tmo) begin
        n.tmo = 1; n.in_en = 0; n.out_en = 0; n.dma = 0; n.st = MIdle; n.wd = 0;
      end else begin
        n.wd = m.wd + 1;
      end
    end else begin
      n.wd = 0;
    end
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ma <= '{default: 0};
      mb <= '{default: 0};
    end else begin
      ma <= step(ma, cfg_a, sa);
      mb <= step(mb, cfg_b, sb);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("a_in_en", a_in_en, ma.in_en);
    chk("a_out_en", a_out_en, ma.out_en);
    chk("a_cmd_en", a_cmd, ma.cmd_en);
    chk("a_dma_rdy", a_dma, ma.dma);
    chk("a_timeout", a_tmo, ma.tmo);
    chk("a_addr", a_addr, ma.addr);
    chk("a_host_rdy", a_host, !rst && ma.st != MOut);
    chk("b_in_en", b_in_en, mb.in_en);
    chk("b_out_en", b_out_en, mb.out_en);
    chk("b_cmd_en", b_cmd, mb.cmd_en);
    chk("b_dma_rdy", b_dma, mb.dma);
    chk("b_timeout", b_tmo, mb.tmo);
    chk("b_addr", b_addr, mb.addr);
    chk("b_host_rdy", b_host, !rst && mb.st != MOut);
  endtask

  task automatic tick();
    @(negedge clk);
    check_all();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1);
  end

  initial begin
    int cnt;
    rst = 1'b1;
    sa = '0;
    sb = '0;
    tick();
    tick();
    chk("rst_a_addr", a_addr, 0);
    chk("rst_a_host", a_host, 0);
    chk("rst_b_host", b_host, 0);

    // Ingress alternation 0,1,0,1 with one idle cycle between grants.
    rst = 1'b0;
    sa.master = 1'b1;
    sa.in_ch = 8'h03;
    tick();
    for (int g = 0; g < 4; g++) begin
      chk("in_rr_addr", a_addr, g % 2);
      chk("in_rr_en", a_in_en, 1);
      tick();
      tick();
      sa.in_fin = 1'b1;
      tick();
      sa.in_fin = 1'b0;
      chk("in_gap_en", a_in_en, 0);
      tick();
    end
    sa.in_ch = 8'h00;
    sa.in_fin = 1'b1;
    tick();
    sa.in_fin = 1'b0;

    // Starvation guard: four ingress grants, then egress wins.
    sa.in_ch = 8'h01;
    sa.out_rdy = 1'b1;
    tick();
    for (int g = 0; g < 4; g++) begin
      chk("burst_in_en", a_in_en, 1);
      tick();
      sa.in_fin = 1'b1;
      tick();
      sa.in_fin = 1'b0;
      tick();
    end
    chk("starve_out_en", a_out_en, 1);
    chk("starve_in_en", a_in_en, 0);
    chk("starve_host", a_host, 0);

    // Egress socket rotation 2,3,2 with a one-cycle gap after each clear.
    sa.in_ch = 8'h00;
    sa.out_rdy = 1'b0;
    sa.out_ch = 8'h03;
    tick();
    chk("out_addr0", a_addr, 2);
    chk("out_dma0", a_dma, 1);
    sa.dma_fin = 1'b1;
    tick();
    sa.dma_fin = 1'b0;
    chk("out_clear_wins", a_dma, 0);
    tick();
    chk("out_addr1", a_addr, 3);
    chk("out_dma1", a_dma, 1);
    sa.dma_fin = 1'b1;
    tick();
    sa.dma_fin = 1'b0;
    tick();
    chk("out_addr2", a_addr, 2);
    sa.dma_fin = 1'b1;
    sa.out_fin = 1'b1;
    tick();
    sa.dma_fin = 1'b0;
    sa.out_fin = 1'b0;
    chk("out_exit_en", a_out_en, 0);
    chk("out_exit_dma", a_dma, 0);
    chk("out_exit_host", a_host, 1);

    // Asynchronous reset in the middle of an egress transaction.
    sa.out_rdy = 1'b1;
    tick();
    sa.out_rdy = 1'b0;
    tick();
    chk("pre_rst_dma", a_dma, 1);
    #2;
    rst = 1'b1;
    #1;
    check_all();
    chk("async_out_en", a_out_en, 0);
    chk("async_dma", a_dma, 0);
    chk("async_cmd", a_cmd, 0);
    chk("async_host", a_host, 0);
    @(negedge clk);
    rst = 1'b0;
    sa.out_ch = 8'h00;
    sa.in_ch = 8'h03;
    tick();
    chk("post_rst_addr", a_addr, 0);
    chk("post_rst_in_en", a_in_en, 1);
    sa.in_ch = 8'h00;
    sa.in_fin = 1'b1;
    tick();
    sa.in_fin = 1'b0;

    // Five ingress sockets, base 8, watchdog of 16 cycles.
    sb.master = 1'b1;
    sb.in_ch = 8'h12;
    tick();
    chk("b_grant1", b_addr, 1);
    cnt = 0;
    while (b_in_en === 1'b1 && cnt < 40) begin
      cnt++;
      tick();
    end
    chk("b_wd_cycles", cnt, 16);
    chk("b_wd_pulse", b_tmo, 1);
    tick();
    chk("b_wd_single", b_tmo, 0);
    chk("b_grant4", b_addr, 4);
    repeat (15) tick();
    sb.in_fin = 1'b1;
    tick();
    sb.in_fin = 1'b0;
    chk("b_fin_wins_tmo", b_tmo, 0);
    chk("b_fin_wins_en", b_in_en, 0);
    tick();
    chk("b_grant1_again", b_addr, 1);
    sb.in_ch = 8'h00;
    sb.in_fin = 1'b1;
    tick();
    sb.in_fin = 1'b0;
    sb.out_rdy = 1'b1;
    sb.out_ch = 8'h01;
    tick();
    chk("b_out_en", b_out_en, 1);
    tick();
    chk("b_out_addr", b_addr, 8);
    sb.out_fin = 1'b1;
    sb.out_rdy = 1'b0;
    tick();
    sb.out_fin = 1'b0;

    // Random traffic on both instances against the model.
    for (int c = 0; c < 1500; c++) begin
      sa.master  = ($urandom_range(0, 9) != 0);
      sa.in_ch   = 8'($urandom_range(0, 3));
      sa.in_fin  = ($urandom_range(0, 3) == 0);
      sa.out_rdy = ($urandom_range(0, 2) == 0);
      sa.out_fin = ($urandom_range(0, 7) == 0);
      sa.dma_fin = ($urandom_range(0, 3) == 0);
      sa.out_ch  = 8'($urandom_range(0, 3));
      sb.master  = ($urandom_range(0, 9) != 0);
      sb.in_ch   = 8'($urandom_range(0, 31));
      sb.in_fin  = ($urandom_range(0, 24) == 0);
      sb.out_rdy = ($urandom_range(0, 2) == 0);
      sb.out_fin = ($urandom_range(0, 24) == 0);
      sb.dma_fin = ($urandom_range(0, 12) == 0);
      sb.out_ch  = 8'($urandom_range(0, 3));
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
